countdown_timer_4bit: RTL and testbench

Loadable down-counter with terminal-count borrow pulse; the counting counterpart to the team's 4-bit up-counter. Software or a controller loads a start value over a valid/ready handshake. The block decrements on each enabled tick and flags the terminal count with a one-cycle `bout`. It then either stops or auto-reloads. The `en` input accepts any tick source, including an up-counter's `cout`, so timers cascade into prescaled intervals.

---
 rtl/countdown_pkg.sv | 12 +
 rtl/countdown_timer_4bit.sv | 74 +++++++
 tb/tb_countdown_timer_4bit.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// countdown_pkg: shared types and constants for the countdown timer.
// Holds the FSM state encoding and the default counter width.
package countdown_pkg;

  typedef enum logic {
    CD_IDLE = 1'b0,
    CD_RUN  = 1'b1
  } cd_state_t;

  localparam int CD_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/countdown_timer_4bit.sv
// countdown_timer_4bit: loadable down-counter, one-cycle borrow pulse.
// Ports: clk, rst_n, load_valid/load_ready/load_val/load_auto (load),
//        en (tick), abort, cnt, bout (terminal pulse), busy (RUN).
module countdown_timer_4bit
  import countdown_pkg::*;
#(
  parameter int WIDTH = CD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_val,
  input  logic             load_auto,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt,
  output logic             bout,
  output logic             busy
);

  cd_state_t        state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] reload_q;
  logic             auto_q;
  logic             bout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CD_IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      auto_q   <= 1'b0;
      bout_q   <= 1'b0;
    end else begin
      bout_q <= 1'b0;
      unique case (state_q)
        CD_IDLE: begin
          if (load_valid) begin
            cnt_q    <= load_val;
            reload_q <= load_val;
            auto_q   <= load_auto;
            state_q  <= CD_RUN;
          end
        end
        CD_RUN: begin
          if (abort) begin
            state_q <= CD_IDLE;
            cnt_q   <= '0;
          end else if (en) begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end else begin
              // terminal tick: pulse, then reload or stop
              bout_q <= 1'b1;
              if (auto_q) begin
                cnt_q <= reload_q;
              end else begin
                state_q <= CD_IDLE;
              end
            end
          end
        end
        default: state_q <= CD_IDLE;
      endcase
    end
  end

  assign load_ready = (state_q == CD_IDLE);
  assign busy       = (state_q == CD_RUN);
  assign cnt        = cnt_q;
  assign bout       = bout_q;

endmodule

// File: tb/tb_countdown_timer_4bit.sv
// tb_countdown_timer_4bit: table, directed and random checks
// of the countdown timer against an arithmetic reference model.
module tb_countdown_timer_4bit;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_val;
  logic         load_auto;
  logic         en;
  logic         abort;
  logic [W-1:0] cnt;
  logic         bout;
  logic         busy;

  countdown_timer_4bit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_val(load_val),
    .load_auto(load_auto),
    .en(en),
    .abort(abort),
    .cnt(cnt),
    .bout(bout),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // reference model: counts enabled ticks since the load and
  // derives the count from the period N+1
  bit m_run;
  bit m_auto;
  int m_n;
  int m_k;
  int m_cnt;
  bit m_bout;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_auto = 1'b0;
    m_n    = 0;
    m_k    = 0;
    m_cnt  = 0;
    m_bout = 1'b0;
  endtask

  task automatic model_edge(input bit lv, input int v, input bit am,
                            input bit e, input bit ab);
    m_bout = 1'b0;
    if (!m_run) begin
      if (lv) begin
        m_run  = 1'b1;
        m_n    = v;
        m_auto = am;
        m_k    = 0;
        m_cnt  = v;
      end
    end else if (ab) begin
      m_run = 1'b0;
      m_cnt = 0;
    end else if (e) begin
      m_k++;
      if (m_k % (m_n + 1) == 0) begin
        m_bout = 1'b1;
        if (!m_auto) begin
          m_run = 1'b0;
          m_cnt = 0;
        end else begin
          m_cnt = m_n;
        end
      end else begin
        m_cnt = m_n - (m_k % (m_n + 1));
      end
    end
  endtask

  task automatic drive(input bit lv, input int v, input bit am,
                       input bit e, input bit ab);
    load_valid = lv;
    load_val   = W'(v);
    load_auto  = am;
    en         = e;
    abort      = ab;
    @(posedge clk);
    model_edge(lv, v, am, e, ab);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".cnt"}, int'(cnt), m_cnt);
    chk({tag, ".bout"}, int'(bout), int'(m_bout));
    chk({tag, ".busy"}, int'(busy), int'(m_run));
    chk({tag, ".ready"}, int'(load_ready), int'(!m_run));
  endtask

  task automatic step(input string tag, input bit lv, input int v,
                      input bit am, input bit e, input bit ab);
    drive(lv, v, am, e, ab);
    chk_model(tag);
  endtask

  typedef struct {
    bit lv;
    int v;
    bit am;
    bit e;
    bit ab;
    int x_cnt;
    bit x_bout;
    bit x_busy;
    bit x_rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit lv, int v, bit am, bit e, bit ab,
                              int c, bit b, bit bz, bit r);
    vec_t t;
    t.lv = lv; t.v = v; t.am = am; t.e = e; t.ab = ab;
    t.x_cnt = c; t.x_bout = b; t.x_busy = bz; t.x_rdy = r;
    return t;
  endfunction

  initial begin
    int seen;
    int ticks;
    n_cmp = 0;
    n_bad = 0;
    model_reset();
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_val   = '0;
    load_auto  = 1'b0;
    en         = 1'b0;
    abort      = 1'b0;
    #12;
    chk("rst.cnt", int'(cnt), 0);
    chk("rst.bout", int'(bout), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.ready", int'(load_ready), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // one-shot N=3, then auto N=2 for 12 ticks, then abort
    tbl.push_back(mk(1, 3, 0, 1, 0, 3, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 2, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 2, 1, 1, 0, 2, 0, 1, 0));
    for (int r = 0; r < 4; r++) begin
      tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 2, 1, 1, 0));
    end
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1));

    foreach (tbl[i]) begin
      drive(tbl[i].lv, tbl[i].v, tbl[i].am, tbl[i].e, tbl[i].ab);
      chk($sformatf("tbl%0d.cnt", i), int'(cnt), tbl[i].x_cnt);
      chk($sformatf("tbl%0d.bout", i), int'(bout), int'(tbl[i].x_bout));
      chk($sformatf("tbl%0d.busy", i), int'(busy), int'(tbl[i].x_busy));
      chk($sformatf("tbl%0d.rdy", i), int'(load_ready),
          int'(tbl[i].x_rdy));
    end

    // load 5, en at 50% duty: bout after exactly 6 enabled ticks
    step("d5.load", 1, 5, 0, 0, 0);
    seen  = -1;
    ticks = 0;
    for (int i = 0; i < 14; i++) begin
      bit e;
      e = (i % 2 == 0);
      if (e) ticks++;
      step("d5", 0, 0, 0, e, 0);
      if (bout && seen < 0) seen = ticks;
    end
    chk("d5.bout_tick", seen, 6);

    // load_valid held in RUN is ignored; abort at cnt=0 with en
    step("ab.load", 1, 1, 0, 0, 0);
    step("ab.hold", 1, 9, 1, 1, 0);
    chk("ab.cnt0", int'(cnt), 0);
    step("ab.abort", 1, 9, 1, 1, 1);
    chk("ab.nobout", int'(bout), 0);
    chk("ab.idle", int'(busy), 0);
    step("ab.reload", 1, 9, 0, 0, 0);
    chk("ab.newcnt", int'(cnt), 9);
    step("ab.stop", 0, 0, 0, 0, 1);

    // async reset mid-count at cnt=7 in auto mode
    step("ar.load", 1, 9, 1, 1, 0);
    step("ar.t1", 0, 0, 0, 1, 0);
    step("ar.t2", 0, 0, 0, 1, 0);
    chk("ar.at7", int'(cnt), 7);
    #4;
    rst_n = 1'b0;
    #1;
    chk("ar.cnt", int'(cnt), 0);
    chk("ar.bout", int'(bout), 0);
    chk("ar.busy", int'(busy), 0);
    chk("ar.ready", int'(load_ready), 1);
    #2;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk_model("ar.post");

    // load 15 counts to 0 without wrapping
    step("w15.load", 1, 15, 0, 1, 0);
    for (int i = 0; i < 16; i++) step("w15", 0, 0, 0, 1, 0);
    chk("w15.bout", int'(bout), 1);
    step("w15.after", 0, 0, 0, 1, 0);
    chk("w15.nowrap", int'(cnt), 0);

    // load 0 auto: bout every enabled cycle, drops when en falls
    step("z.load", 1, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step("z.run", 0, 0, 0, 1, 0);
      chk("z.bout", int'(bout), 1);
    end
    step("z.off", 0, 0, 0, 0, 0);
    chk("z.drop", int'(bout), 0);
    step("z.stop", 0, 0, 0, 0, 1);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step("rnd",
           $urandom_range(2, 0) == 0,
           int'($urandom_range(15, 0)),
           $urandom_range(1, 0) == 1,
           $urandom_range(9, 0) < 6,
           $urandom_range(15, 0) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
